i2c_bit_timer: RTL and testbench

Programmable bit-period timer for the I2C controller. A SIZE-bit counter runs from 0 to Ticks-1 and emits a one-cycle Out pulse on each wrap, giving one pulse every Ticks enabled clock cycles. Start restarts and holds the period. Stop freezes the count. The bit/byte controller uses Out as its SCL/SDA phase tick.

---
 rtl/i2c_bit_timer.sv | 51 +++++
 tb/tb_i2c_bit_timer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bit_timer.sv
// Programmable bit-period timer: counts 0..Ticks-1 and pulses Out for one
// cycle on each wrap, giving the SCL/SDA phase tick for the bit/byte controller.
module i2c_bit_timer #(
    parameter int unsigned SIZE = 8
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic [SIZE-1:0] Ticks,
    input  logic            Start,
    input  logic            Stop,
    output logic            Out,
    output logic [SIZE-1:0] OutCount
);

    logic [SIZE-1:0] count_nxt;
    logic            out_nxt;
    logic            wrap_c;

    // Next-state selection in priority order: restart, disabled, pause, wrap, count.
    // The >= compare lets a Ticks decrease below the current count wrap at once
    // instead of running up to the counter's full range.
    always_comb begin
        count_nxt = OutCount;
        out_nxt   = 1'b0;
        wrap_c    = (OutCount >= (Ticks - SIZE'(1)));
        if (Start) begin
            count_nxt = '0;
        end else if (Ticks == '0) begin
            count_nxt = '0;
        end else if (Stop) begin
            count_nxt = OutCount;
        end else if (wrap_c) begin
            count_nxt = '0;
            out_nxt   = 1'b1;
        end else begin
            count_nxt = OutCount + SIZE'(1);
        end
    end

    // Rst_n is an active-high asynchronous reset despite its name.
    always_ff @(posedge Clk or posedge Rst_n) begin
        if (Rst_n) begin
            OutCount <= '0;
            Out      <= 1'b0;
        end else begin
            OutCount <= count_nxt;
            Out      <= out_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_bit_timer.sv
// Self-checking bench for i2c_bit_timer: vector table, corner-case sequences,
// and randomized traffic against a cycle-level reference model.
module tb_i2c_bit_timer;

    localparam int unsigned SIZE = 8;

    logic            Clk;
    logic            Rst_n;
    logic [SIZE-1:0] Ticks;
    logic            Start;
    logic            Stop;
    logic            Out;
    logic [SIZE-1:0] OutCount;

    i2c_bit_timer #(.SIZE(SIZE)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Ticks    (Ticks),
        .Start    (Start),
        .Stop     (Stop),
        .Out      (Out),
        .OutCount (OutCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic            start;
        logic            stop;
        logic [SIZE-1:0] ticks;
        logic            exp_out;
        logic [SIZE-1:0] exp_cnt;
    } vec_t;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  m_cnt   = 0;   // model: enabled cycles elapsed in the current period
    bit  m_out   = 0;
    bit  prev_out = 0;
    time last_rise = 0;
    time gap = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a period is Ticks enabled cycles; the pulse marks its completion.
    task automatic model_edge(input bit st, input bit sp, input int tk);
        if (st || tk == 0) begin
            m_cnt = 0;
            m_out = 0;
        end else if (sp) begin
            m_out = 0;
        end else if (m_cnt + 1 >= tk) begin
            m_cnt = 0;
            m_out = 1;
        end else begin
            m_cnt = m_cnt + 1;
            m_out = 0;
        end
    endtask

    task automatic step(input logic st, input logic sp, input logic [SIZE-1:0] tk);
        Start = st;
        Stop  = sp;
        Ticks = tk;
        @(posedge Clk);
        #1;
        model_edge(st, sp, int'(tk));
        if (Out && !prev_out) begin
            gap = $time - last_rise;
            last_rise = $time;
        end
        prev_out = Out;
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_out = 0;
        prev_out = 0;
    endtask

    vec_t vecs[$];
    int   bad;
    logic [SIZE-1:0] rtk;

    initial begin
        Rst_n = 1'b0;
        Start = 1'b0;
        Stop  = 1'b0;
        Ticks = SIZE'(4);
        #2 Rst_n = 1'b1;
        #1;
        check("reset_out", Out, 0);
        check("reset_cnt", OutCount, 0);
        @(posedge Clk);
        #1;
        check("reset_held_cnt", OutCount, 0);
        Rst_n = 1'b0;
        model_reset();

        // Ticks=4 free-running, then restart with Ticks=8 and a 2-cycle pause at 4
        for (int i = 0; i < 2; i++) begin
            vecs.push_back('{1'b0, 1'b0, 8'd4, 1'b0, 8'd1});
            vecs.push_back('{1'b0, 1'b0, 8'd4, 1'b0, 8'd2});
            vecs.push_back('{1'b0, 1'b0, 8'd4, 1'b0, 8'd3});
            vecs.push_back('{1'b0, 1'b0, 8'd4, 1'b1, 8'd0});
        end
        vecs.push_back('{1'b1, 1'b0, 8'd8, 1'b0, 8'd0});
        for (int i = 1; i <= 4; i++) vecs.push_back('{1'b0, 1'b0, 8'd8, 1'b0, 8'(i)});
        vecs.push_back('{1'b0, 1'b1, 8'd8, 1'b0, 8'd4});
        vecs.push_back('{1'b0, 1'b1, 8'd8, 1'b0, 8'd4});
        for (int i = 5; i <= 7; i++) vecs.push_back('{1'b0, 1'b0, 8'd8, 1'b0, 8'(i)});
        vecs.push_back('{1'b0, 1'b0, 8'd8, 1'b1, 8'd0});

        foreach (vecs[i]) begin
            step(vecs[i].start, vecs[i].stop, vecs[i].ticks);
            check($sformatf("vec%0d_out", i), Out, vecs[i].exp_out);
            check($sformatf("vec%0d_cnt", i), OutCount, vecs[i].exp_cnt);
            if (i == 7) check("ticks4_period_ns", gap, 40);
        end

        // Ticks=8: pause 2 cycles mid-period stretches it to 10 cycles, next is 8
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'd8);
        step(1'b0, 1'b1, 8'd8);
        step(1'b0, 1'b1, 8'd8);
        check("stop_hold_cnt", OutCount, 4);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'd8);
        check("stop_wrap_out", Out, 1);
        check("stop_period_ns", gap, 100);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'd8);
        check("after_stop_period_ns", gap, 80);

        $display("[TB] note: Ticks is 0 -> timer disabled, expecting no pulses");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 8'd0);
            if (Out !== 1'b0 || OutCount !== 8'd0) bad++;
        end
        check("ticks0_bad_cycles", bad, 0);

        // Ticks=1: Out continuously high except during Stop
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 8'd1);
            if (Out !== 1'b1 || OutCount !== 8'd0) bad++;
        end
        check("ticks1_bad_cycles", bad, 0);
        step(1'b0, 1'b1, 8'd1);
        check("ticks1_stop1_out", Out, 0);
        step(1'b0, 1'b1, 8'd1);
        check("ticks1_stop2_out", Out, 0);
        step(1'b0, 1'b0, 8'd1);
        check("ticks1_resume_out", Out, 1);

        // Ticks=6: Start with Stop at count 3 wins; first pulse 6 edges after release
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd6);
        check("ticks6_pre_cnt", OutCount, 3);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'd6);
            if (Out !== 1'b0 || OutCount !== 8'd0) bad++;
        end
        check("start_stop_bad_cycles", bad, 0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 8'd6);
            if (Out !== 1'b0) bad++;
        end
        check("start_early_pulses", bad, 0);
        step(1'b0, 1'b0, 8'd6);
        check("start_first_out", Out, 1);
        check("start_first_cnt", OutCount, 0);

        // Ticks dropped from 10 to 4 at count 7: wrap at once, then 4-cycle period
        step(1'b1, 1'b0, 8'd10);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'd10);
        check("ticks10_cnt", OutCount, 7);
        step(1'b0, 1'b0, 8'd4);
        check("shrink_wrap_out", Out, 1);
        check("shrink_wrap_cnt", OutCount, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'd4);
        check("shrink_period_ns", gap, 40);
        step(1'b0, 1'b0, 8'd4);
        step(1'b0, 1'b0, 8'd4);
        check("pre_async_cnt", OutCount, 2);

        // Asynchronous reset mid-cycle takes effect before any clock edge
        #2 Rst_n = 1'b1;
        #1;
        check("async_rst_out", Out, 0);
        check("async_rst_cnt", OutCount, 0);
        @(posedge Clk);
        #1;
        check("async_rst_held_cnt", OutCount, 0);
        Rst_n = 1'b0;
        model_reset();

        // Randomized traffic against the reference model
        rtk = 8'd5;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 9) == 0) rtk = 8'($urandom_range(100, 255));
                else rtk = 8'($urandom_range(0, 12));
            end
            step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 6) == 0), rtk);
            if (Out !== m_out || int'(OutCount) != m_cnt) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL rand_cycle%0d: Out=%0b OutCount=%0d, expected Out=%0b OutCount=%0d",
                             i, Out, OutCount, m_out, m_cnt);
            end
        end
        check("rand_bad_cycles", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
